// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, one multiplier bit retired
// every two clocks (EVAL then SHIFT), with a one-cycle done pulse.
// Optional feature macro: SEQ_MULT_SIGNED_EN selects two's-complement operands
// and product; when undefined the unit is purely unsigned.
module seq_multiplier #(
  parameter int nBit = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [nBit-1:0]   a,
  input  logic [nBit-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*nBit-1:0] product
);

  localparam int CW = (nBit > 1) ? $clog2(nBit) : 1;
  localparam logic [CW-1:0] LAST = CW'(nBit - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    SHIFT  = 2'd2,
    DONE_S = 2'd3
  } state_t;

  state_t          state;
  logic [nBit-1:0] m;
  logic [nBit-1:0] q;
  logic [nBit-1:0] p;
  logic            c;
  logic [CW-1:0]   cnt;
`ifdef SEQ_MULT_SIGNED_EN
  logic            sgn;
`endif

  // (nBit+1)-bit partial-product accumulation; the top bit becomes the carry.
  function automatic logic [nBit:0] add_step(input logic [nBit-1:0] acc,
                                             input logic [nBit-1:0] mcand);
    return {1'b0, acc} + {1'b0, mcand};
  endfunction

  // Operand as loaded into the datapath: magnitude in signed mode, as-is otherwise.
  // The most negative value wraps to 2^(nBit-1), which is exact as unsigned.
  function automatic logic [nBit-1:0] operand_mag(input logic [nBit-1:0] v);
`ifdef SEQ_MULT_SIGNED_EN
    return v[nBit-1] ? (~v + 1'b1) : v;
`else
    return v;
`endif
  endfunction

`ifdef SEQ_MULT_SIGNED_EN
  // Reapply the result sign to the unsigned magnitude product.
  function automatic logic [2*nBit-1:0] apply_sign(input logic [2*nBit-1:0] mag,
                                                   input logic            neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction
`endif

  // Controller and datapath: state, iteration registers and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      q       <= '0;
      p       <= '0;
      c       <= 1'b0;
      cnt     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= operand_mag(a);
            q     <= operand_mag(b);
            p     <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn   <= a[nBit-1] ^ b[nBit-1];
`endif
            busy  <= 1'b1;
            state <= EVAL;
          end
        end

        EVAL: begin
          if (q[0]) begin
            {c, p} <= add_step(p, m);
          end
          state <= SHIFT;
        end

        SHIFT: begin
          // Logical right shift of the (2*nBit+1)-bit {C,P,Q} chain.
          c <= 1'b0;
          p <= {c, p[nBit-1:1]};
          q <= {p[0], q[nBit-1:1]};
          if (cnt == LAST) begin
            // Product is captured from the post-shift value on the edge entering DONE.
`ifdef SEQ_MULT_SIGNED_EN
            product <= apply_sign({c, p, q[nBit-1:1]}, sgn);
`else
            product <= {c, p, q[nBit-1:1]};
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE_S;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= EVAL;
          end
        end

        DONE_S: begin
          // Start here is ignored; the next accept can only come from IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
